// File: rtl/xunit_sha_pkg.sv
// Shared constants, state encoding and SHA-2 message-schedule sigma helpers
// for the xunit message scheduler.
package xunit_sha_pkg;

  localparam int unsigned WIN_DEPTH = 16;
  localparam int unsigned LOAD_LAST = WIN_DEPTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_GEN   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam int unsigned S256_S0_R0 = 7;
  localparam int unsigned S256_S0_R1 = 18;
  localparam int unsigned S256_S0_SH = 3;
  localparam int unsigned S256_S1_R0 = 17;
  localparam int unsigned S256_S1_R1 = 19;
  localparam int unsigned S256_S1_SH = 10;

  localparam int unsigned S512_S0_R0 = 1;
  localparam int unsigned S512_S0_R1 = 8;
  localparam int unsigned S512_S0_SH = 7;
  localparam int unsigned S512_S1_R0 = 19;
  localparam int unsigned S512_S1_R1 = 61;
  localparam int unsigned S512_S1_SH = 6;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] sig0_256(input logic [31:0] x);
    return rotr32(x, S256_S0_R0) ^ rotr32(x, S256_S0_R1) ^ (x >> S256_S0_SH);
  endfunction

  function automatic logic [31:0] sig1_256(input logic [31:0] x);
    return rotr32(x, S256_S1_R0) ^ rotr32(x, S256_S1_R1) ^ (x >> S256_S1_SH);
  endfunction

  function automatic logic [63:0] sig0_512(input logic [63:0] x);
    return rotr64(x, S512_S0_R0) ^ rotr64(x, S512_S0_R1) ^ (x >> S512_S0_SH);
  endfunction

  function automatic logic [63:0] sig1_512(input logic [63:0] x);
    return rotr64(x, S512_S1_R0) ^ rotr64(x, S512_S1_R1) ^ (x >> S512_S1_SH);
  endfunction

endpackage

// File: rtl/xunit_msched_sigma.sv
// Combinational next-schedule-word generator: sigma1(w14) + w9 + sigma0(w1) + w0,
// SHA-256 on the low 32 bits (upper bits zero) or SHA-512 when mode is set.
module xunit_msched_sigma
  import xunit_sha_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              mode,
  input  logic [DATA_W-1:0] w14,
  input  logic [DATA_W-1:0] w9,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] w0,
  output logic [DATA_W-1:0] val_c
);

  logic [31:0] sum256_c;

  assign sum256_c = sig1_256(w14[31:0]) + w9[31:0] + sig0_256(w1[31:0]) + w0[31:0];

  if (DATA_W == 64) begin : g_wide
    logic [63:0] sum512_c;
    assign sum512_c = sig1_512(w14[63:0]) + w9[63:0] + sig0_512(w1[63:0]) + w0[63:0];
    assign val_c    = mode ? DATA_W'(sum512_c) : DATA_W'(sum256_c);
  end else begin : g_narrow
    // 32-bit build has no SHA-512 path; mode is meaningless here.
    assign val_c = DATA_W'(sum256_c);
  end

endmodule

// File: rtl/xunit_msched.sv
// SHA-256/SHA-512 message scheduler: optional start delay, 16 loaded words,
// then gen0 generated words streamed one per running cycle on out0.
module xunit_msched
  import xunit_sha_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DELAY_W = 7,
  parameter int unsigned GEN_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  input  logic [DELAY_W-1:0] delay0,
  input  logic               mode,
  input  logic [GEN_W-1:0]   gen0
);

  localparam int unsigned       CNT_W   = (GEN_W > 4) ? GEN_W : 4;
  localparam logic              IS64    = (DATA_W == 64);
  localparam logic [DATA_W-1:0] LO_MASK = DATA_W'(32'hFFFF_FFFF);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               mode_q, mode_d;
  logic               done_d;
  logic               shift_c;
  logic               gen_sel_c;
  logic [DATA_W-1:0]  val_c;
  logic [DATA_W-1:0]  word_c;
  logic [DATA_W-1:0]  win [WIN_DEPTH];

  xunit_msched_sigma #(.DATA_W(DATA_W)) u_sigma (
    .mode  (mode_q),
    .w14   (win[14]),
    .w9    (win[9]),
    .w1    (win[1]),
    .w0    (win[0]),
    .val_c (val_c)
  );

  // SHA-256 words never carry anything above bit 31.
  assign word_c = (gen_sel_c ? val_c : in0) & (mode_q ? {DATA_W{1'b1}} : LO_MASK);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    gen_d     = gen_q;
    mode_d    = mode_q;
    shift_c   = 1'b0;
    gen_sel_c = 1'b0;
    if (run) begin
      // A start pulse wins over freeze and over any operation in flight.
      dly_d   = delay0;
      gen_d   = gen0;
      mode_d  = mode & IS64;
      cnt_d   = '0;
      state_d = (delay0 == '0) ? ST_LOAD : ST_DELAY;
    end else if (running) begin
      unique case (state_q)
        ST_DELAY: begin
          dly_d = dly_q - DELAY_W'(1);
          if (dly_q == DELAY_W'(1)) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          shift_c = 1'b1;
          if (cnt_q == CNT_W'(LOAD_LAST)) begin
            cnt_d   = '0;
            state_d = (gen_q == '0) ? ST_FIN : ST_GEN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GEN: begin
          shift_c   = 1'b1;
          gen_sel_c = 1'b1;
          if (cnt_q == CNT_W'(gen_q - GEN_W'(1))) begin
            cnt_d   = '0;
            state_d = ST_FIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    done_d = (state_d == ST_IDLE) || (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      cnt_q   <= '0;
      gen_q   <= '0;
      mode_q  <= 1'b0;
      done    <= 1'b1;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      gen_q   <= gen_d;
      mode_q  <= mode_d;
      done    <= done_d;
    end
  end

  // Sliding 16-word window; out0 mirrors the word just written into w[15].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(WIN_DEPTH); i++) win[i] <= '0;
      out0 <= '0;
    end else if (shift_c) begin
      for (int i = 0; i < int'(WIN_DEPTH) - 1; i++) win[i] <= win[i+1];
      win[WIN_DEPTH-1] <= word_c;
      out0             <= word_c;
    end
  end

endmodule

// File: doc/xunit_msched.md
XUNIT_MSCHED -- requirements
Module: xunit_msched

Interface
REQ-001 SHALL have parameter DATA_W, default 64, giving the word width; only 32 and 64 are legal.
REQ-002 SHALL have parameter DELAY_W, default 7, giving the width of delay0.
REQ-003 SHALL have parameter GEN_W, default 7, giving the width of gen0.
REQ-004 SHALL have port clk  input  1  as its single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  as the reset, asynchronous and active-low.
REQ-006 SHALL have port running  input  1  which advances the datapath while high and freezes all state while low.
REQ-007 SHALL have port run  input  1  which is a start pulse.
REQ-008 SHALL have port done  output  1  which is high when idle or finished.
REQ-009 SHALL have port in0  input  DATA_W  carrying message words W0..W15.
REQ-010 SHALL have port out0  output  DATA_W  carrying the registered schedule word stream.
REQ-011 SHALL have port delay0  input  DELAY_W  giving the cycles to wait before the first valid in0.
REQ-012 SHALL have port mode  input  1  selecting the algorithm: 0 = SHA-256 (32-bit words), 1 = SHA-512 (64-bit words, legal only when DATA_W=64).
REQ-013 SHALL have port gen0  input  GEN_W  giving the number of generated words after the 16 loaded words: 48 for SHA-256, 64 for SHA-512.

Function
REQ-014 SHALL implement states IDLE, DELAY, LOAD, GEN and FIN.
REQ-015 SHALL, on run high in any state, capture delay0, mode and gen0, clear the word counter and enter DELAY (or LOAD if delay0=0); run has priority over every other event.
REQ-016 SHALL, in DELAY, decrement the delay counter on each running cycle and enter LOAD on the cycle the counter reaches 0.
REQ-017 SHALL, in LOAD, on each running cycle shift the 16-entry window (w[i] <= w[i+1]), write in0 into w[15] and register out0 <= in0, for exactly 16 cycles.
REQ-018 SHALL, in GEN, on each running cycle compute val = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], write val into w[15] with the shift, and register out0 <= val, for exactly gen0 cycles.
REQ-019 SHALL use the following functions in SHA-256 mode: sigma0 = ROTR7^ROTR18^SHR3 and sigma1 = ROTR17^ROTR19^SHR10, on the low 32 bits, with the sum taken mod 2^32 and the upper bits of out0 and the window forced to 0.
REQ-020 SHALL use the following functions in SHA-512 mode: sigma0 = ROTR1^ROTR8^SHR7 and sigma1 = ROTR19^ROTR61^SHR6, with the sum taken mod 2^64.
REQ-021 SHALL have a latency of 1 cycle from a word presented or generated to its appearance on out0; word t appears on out0 on the (t+1)-th running cycle after LOAD entry.
REQ-022 SHALL, with gen0=0, go from LOAD directly to FIN.
REQ-023 SHALL, in FIN, hold out0 at the last word and keep done high until the next run.
REQ-024 SHALL drive done low in DELAY, LOAD and GEN, and high in IDLE and FIN.
REQ-025 SHALL, while running is low, change no register, so that a frozen cycle never drops or duplicates a word.
REQ-026 SHALL ignore mode=1 when DATA_W=32 and treat it as mode=0.

Reset
REQ-027 SHALL, on rst low, immediately clear state to IDLE, set done=1, out0=0, the window to 0 and all counters to 0, regardless of clk or running.
REQ-028 SHALL, when reset is asserted mid-operation, abort that operation; after release the block SHALL do nothing until a new run.

Structure
REQ-029 SHALL keep the state encoding, the 16-entry window depth and the SHA-256/SHA-512 rotation and shift constants in a shared package, xunit_sha_pkg.
REQ-030 SHALL place the sigma0/sigma1 computation and mode-muxed adder in a single sub-module, xunit_msched_sigma, which is combinational and parametrised by DATA_W.

Verification
REQ-031 SHALL be verified with SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x18), delay0=0, gen0=48 -> out0 words 16 and 17 = 0x61626380 and 0x000F0000; done rises one cycle after the 64th word.
REQ-032 SHALL be verified with SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18), gen0=64 -> words 16 and 17 = 0x6162638000000000 and 0x00030000000000C0; 80 words in total.
REQ-033 SHALL be verified with delay0=5 and the SHA-256 vector -> done low for 5+16+48 running cycles, and the first out0 equals W0 at cycle 6.
REQ-034 SHALL be verified with running deasserted for 3 cycles at word 20 -> out0 frozen, and the resumed stream bit-identical to the unstalled run.
REQ-035 SHALL be verified with run re-pulsed during GEN at word 30 -> the prior operation is discarded, done goes low, and the new 64-word sequence is correct.
REQ-036 SHALL be verified with rst pulsed low mid-GEN -> out0=0 and done=1 asynchronously; no activity until the next run; gen0=0 -> done high after 16 words.
